// File: rtl/key_tone_encoder.sv
// Piano key front end: synchronises, debounces and priority-encodes eight keys, then drives
// the 7-seg note pattern, a free-running beat strobe and a square-wave buzzer tone.
module key_tone_encoder #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int BEAT_DIV   = 25_000_000,
    parameter int SIM_DIV    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keys,
    output logic [7:0] TONE_data,
    output logic [3:0] note,
    output logic       note_valid,
    output logic       beat,
    output logic       buzz
);

    localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int BCNT_W = $clog2(BEAT_DIV);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BEAT_DIV - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    function automatic logic [7:0] seg_pat(input logic [3:0] n);
        case (n)
            4'd1:    seg_pat = 8'hF9;
            4'd2:    seg_pat = 8'hA4;
            4'd3:    seg_pat = 8'hB0;
            4'd4:    seg_pat = 8'h99;
            4'd5:    seg_pat = 8'h92;
            4'd6:    seg_pat = 8'h82;
            4'd7:    seg_pat = 8'hF8;
            4'd8:    seg_pat = 8'h79;
            default: seg_pat = 8'hFF;
        endcase
    endfunction

    // Shifted table entries are clamped to 1 so a large SIM_DIV never stalls the tone counter.
    function automatic logic [16:0] half_period(input logic [3:0] n);
        logic [16:0] tbl;
        logic [16:0] hp;
        case (n)
            4'd1:    tbl = 17'd95556;
            4'd2:    tbl = 17'd85131;
            4'd3:    tbl = 17'd75843;
            4'd4:    tbl = 17'd71586;
            4'd5:    tbl = 17'd63776;
            4'd6:    tbl = 17'd56818;
            4'd7:    tbl = 17'd50619;
            4'd8:    tbl = 17'd47778;
            default: tbl = 17'd1;
        endcase
        hp = tbl >> SIM_DIV;
        if (hp == 17'd0) hp = 17'd1;
        half_period = hp;
    endfunction

    logic [7:0]        keys_p0;
    logic [7:0]        ks;
    logic [3:0]        cand;
    state_t            state, state_nxt;
    logic [3:0]        pend, pend_nxt;
    logic [DCNT_W-1:0] dcnt, dcnt_nxt, dcnt_inc;
    logic [3:0]        note_nxt;
    logic              vld_nxt;
    logic [16:0]       tcnt;
    logic [16:0]       hp;
    logic [BCNT_W-1:0] bcnt;

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_p0 <= '0;
            ks      <= '0;
        end else begin
            keys_p0 <= keys;
            ks      <= keys_p0;
        end
    end

    always_comb begin
        cand = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ks[i]) cand = 4'(i + 1);
        end
    end

    assign dcnt_inc = dcnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend       <= '0;
            dcnt       <= '0;
            note       <= '0;
            note_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend       <= pend_nxt;
            dcnt       <= dcnt_nxt;
            note       <= note_nxt;
            note_valid <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        dcnt_nxt  = dcnt;
        note_nxt  = note;
        vld_nxt   = note_valid;
        case (state)
            IDLE: begin
                if (cand != 4'd0) begin
                    state_nxt = DEBOUNCE;
                    pend_nxt  = cand;
                    dcnt_nxt  = '0;
                end
            end
            DEBOUNCE: begin
                if (cand != pend) begin
                    dcnt_nxt = '0;
                    if (cand == 4'd0) begin
                        state_nxt = note_valid ? RELEASE : IDLE;
                    end else begin
                        pend_nxt = cand;
                    end
                end else if (dcnt_inc >= DCNT_LAST) begin
                    state_nxt = PRESSED;
                    note_nxt  = pend;
                    vld_nxt   = 1'b1;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = dcnt_inc;
                end
            end
            PRESSED: begin
                if (cand == 4'd0) begin
                    state_nxt = RELEASE;
                    dcnt_nxt  = '0;
                end else if (cand != note) begin
                    state_nxt = DEBOUNCE;
                    pend_nxt  = cand;
                    dcnt_nxt  = '0;
                end
            end
            RELEASE: begin
                if (cand != 4'd0) begin
                    state_nxt = DEBOUNCE;
                    pend_nxt  = cand;
                    dcnt_nxt  = '0;
                end else if (dcnt_inc >= DCNT_LAST) begin
                    state_nxt = IDLE;
                    note_nxt  = 4'd0;
                    vld_nxt   = 1'b0;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = dcnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        TONE_data = seg_pat(note);
    end

    assign hp = half_period(note);

    // Tone phase restarts whenever the sounding note changes or the key is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            buzz <= 1'b0;
        end else if ((note_nxt != note) || !vld_nxt) begin
            tcnt <= '0;
            buzz <= 1'b0;
        end else if (tcnt >= hp - 17'd1) begin
            tcnt <= '0;
            buzz <= ~buzz;
        end else begin
            tcnt <= tcnt + 17'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            beat <= 1'b0;
        end else begin
            beat <= (bcnt == BCNT_LAST);
            bcnt <= (bcnt == BCNT_LAST) ? '0 : bcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_key_tone_encoder.sv
// Directed bench for key_tone_encoder: vector table of steady-state presses plus hand-timed
// sequences for latency, bounce, priority, glitch, reset and beat behaviour.
module tb_key_tone_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] keys = 8'h00;
    logic [7:0] TONE_data;
    logic [3:0] note;
    logic       note_valid;
    logic       beat;
    logic       buzz;

    int checks = 0;
    int errors = 0;

    key_tone_encoder #(.DEB_CYCLES(4), .BEAT_DIV(10), .SIM_DIV(12)) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .TONE_data(TONE_data),
        .note(note), .note_valid(note_valid), .beat(beat), .buzz(buzz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] keys;
        logic [3:0] note;
        logic [7:0] seg;
        logic       vld;
    } vec_t;

    vec_t vt[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] n, input logic [7:0] s, input logic v);
        chk({name, "_note"}, 32'(note), 32'(n));
        chk({name, "_seg"}, 32'(TONE_data), 32'(s));
        chk({name, "_vld"}, 32'(note_valid), 32'(v));
    endtask

    initial begin
        vt[0]  = '{8'h04, 4'd3, 8'hB0, 1'b1};
        vt[1]  = '{8'h00, 4'd0, 8'hFF, 1'b0};
        vt[2]  = '{8'h01, 4'd1, 8'hF9, 1'b1};
        vt[3]  = '{8'h02, 4'd2, 8'hA4, 1'b1};
        vt[4]  = '{8'h08, 4'd4, 8'h99, 1'b1};
        vt[5]  = '{8'h10, 4'd5, 8'h92, 1'b1};
        vt[6]  = '{8'h20, 4'd6, 8'h82, 1'b1};
        vt[7]  = '{8'h40, 4'd7, 8'hF8, 1'b1};
        vt[8]  = '{8'h80, 4'd8, 8'h79, 1'b1};
        vt[9]  = '{8'h81, 4'd1, 8'hF9, 1'b1};
        vt[10] = '{8'hF0, 4'd5, 8'h92, 1'b1};
        vt[11] = '{8'h00, 4'd0, 8'hFF, 1'b0};

        // Reset state
        tick(3);
        chk_out("reset", 4'd0, 8'hFF, 1'b0);
        chk("reset_beat", 32'(beat), 0);
        chk("reset_buzz", 32'(buzz), 0);

        // Beat free-runs from reset release, independent of a key press mid-way
        rst_n = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick(1);
            chk($sformatf("beat_edge%0d", k), 32'(beat), 32'((k % 10) == 0));
            if (k == 3) keys = 8'h04;
        end
        keys = 8'h00;
        tick(8);

        // Steady-state vector table
        for (int i = 0; i < 12; i++) begin
            keys = vt[i].keys;
            tick(8);
            chk_out($sformatf("vec%0d", i), vt[i].note, vt[i].seg, vt[i].vld);
            chk($sformatf("vec%0d_buzz", i), 32'(buzz), 0);
        end

        // Exact press latency and buzz half-period for note 3 (18 cycles)
        keys = 8'h04;
        tick(5);
        chk_out("lat_before", 4'd0, 8'hFF, 1'b0);
        tick(1);
        chk_out("lat_at", 4'd3, 8'hB0, 1'b1);
        tick(17);
        chk("buzz3_e23", 32'(buzz), 0);
        tick(1);
        chk("buzz3_e24", 32'(buzz), 1);
        tick(17);
        chk("buzz3_e41", 32'(buzz), 1);
        tick(1);
        chk("buzz3_e42", 32'(buzz), 0);
        keys = 8'h00;
        tick(8);

        // Bounce: no acceptance until 6 edges after the final settle
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 8'h04 : 8'h00;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                chk("bounce_novalid", 32'(note_valid), 0);
            end
        end
        keys = 8'h04;
        tick(5);
        chk("bounce_before", 32'(note_valid), 0);
        tick(1);
        chk_out("bounce_at", 4'd3, 8'hB0, 1'b1);
        keys = 8'h00;
        tick(8);

        // Priority: note 1 wins, then releasing it re-debounces to note 8 and restarts buzz
        keys = 8'h81;
        tick(30);
        chk_out("prio_81", 4'd1, 8'hF9, 1'b1);
        chk("prio_buzz1", 32'(buzz), 1);
        keys = 8'h80;
        tick(5);
        chk_out("prio_hold", 4'd1, 8'hF9, 1'b1);
        chk("prio_hold_buzz", 32'(buzz), 1);
        tick(1);
        chk_out("prio_80", 4'd8, 8'h79, 1'b1);
        chk("prio_buzz_restart", 32'(buzz), 0);
        tick(10);
        chk("buzz8_e10", 32'(buzz), 0);
        tick(1);
        chk("buzz8_e11", 32'(buzz), 1);

        // Release from note 5 with a 2-cycle glitch that must not drop the note
        keys = 8'h10;
        tick(8);
        chk_out("rel_note5", 4'd5, 8'h92, 1'b1);
        keys = 8'h00;
        tick(2);
        keys = 8'h10;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            chk_out("glitch_hold", 4'd5, 8'h92, 1'b1);
        end
        keys = 8'h00;
        tick(5);
        chk_out("rel_before", 4'd5, 8'h92, 1'b1);
        tick(1);
        chk_out("rel_at", 4'd0, 8'hFF, 1'b0);
        chk("rel_buzz", 32'(buzz), 0);

        // Asynchronous reset mid-press, then full re-debounce of the still-held key
        keys = 8'h04;
        tick(30);
        chk_out("rst_pre", 4'd3, 8'hB0, 1'b1);
        chk("rst_pre_buzz", 32'(buzz), 1);
        rst_n = 1'b0;
        #2;
        chk_out("rst_async", 4'd0, 8'hFF, 1'b0);
        chk("rst_async_buzz", 32'(buzz), 0);
        chk("rst_async_beat", 32'(beat), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5);
        chk("rst_redeb_before", 32'(note_valid), 0);
        tick(1);
        chk_out("rst_redeb_at", 4'd3, 8'hB0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
